// File: rtl/pir_zone_scheduler.sv
// Three-zone PIR alarm sequencer: synchronize/debounce sensors, latch events, round-robin grant, timeout + hold-off.
// Define PIR_BEEP_EN for a pulsed buzzer; otherwise the buzzer is a steady tone mirroring LED.
module pir_zone_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALARM_TIMEOUT   = 1000,
  parameter int HOLDOFF_CYCLES  = 64,
  parameter int BEEP_HALF       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stop_alarm,
  input  logic        pir_sensor_1,
  input  logic        pir_sensor_2,
  input  logic        pir_sensor_3,
  output logic        LED,
  output logic        buzzer,
  output logic [20:0] display_data,
  output logic [1:0]  alarm_zone,
  output logic [2:0]  pending
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ALARM_TIMEOUT + HOLDOFF_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [6:0] SEG_A = 7'b1110111;

  if (DEBOUNCE_CYCLES < 2 || ALARM_TIMEOUT < 2 || HOLDOFF_CYCLES < 1 || BEEP_HALF < 1) begin : g_param_check
    $error("pir_zone_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ALARM, S_HOLDOFF} state_t;
  state_t r_state, w_state_nxt;

  logic [2:0]    r_sens_meta, r_sens_sync, r_deb, w_rise;
  logic          r_stop_meta, r_stop_sync;
  logic [DW-1:0] r_dcnt [3];
  logic [TW-1:0] r_timer;
  logic [1:0]    r_ptr;
  logic          w_grant, w_grant_vld;
  logic [1:0]    w_grant_idx, w_zone_nxt;
  logic [2:0]    w_pend_nxt;
  logic [6:0]    w_digit;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sens_meta <= '0;
      r_sens_sync <= '0;
      r_stop_meta <= 1'b0;
      r_stop_sync <= 1'b0;
      r_deb       <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_sens_meta <= {pir_sensor_3, pir_sensor_2, pir_sensor_1};
      r_sens_sync <= r_sens_meta;
      r_stop_meta <= stop_alarm;
      r_stop_sync <= r_stop_meta;
      for (int i = 0; i < 3; i++) begin
        if (r_sens_sync[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DEB_LAST) begin
          r_dcnt[i] <= '0;
          r_deb[i]  <= r_sens_sync[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  // A rising event is the cycle the debounced level is about to flip 0->1.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < 3; i++)
      w_rise[i] = !r_deb[i] && r_sens_sync[i] && (r_dcnt[i] == DEB_LAST);
  end

  // Scan downward so the candidate closest to the pointer is assigned last and wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (pending[wrap3(3'(r_ptr) + 3'(k))]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = wrap3(3'(r_ptr) + 3'(k));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld && !r_stop_sync) begin
          w_state_nxt = S_ALARM;
          w_grant     = 1'b1;
        end
      end
      S_ALARM:   if (r_stop_sync || r_timer == ALARM_LAST) w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: if (r_timer == HOLD_LAST) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Silence beats new events; a new event beats the grant clear.
  always_comb begin
    w_pend_nxt = pending;
    if (w_grant) w_pend_nxt[w_grant_idx] = 1'b0;
    w_pend_nxt = w_pend_nxt | w_rise;
    if (r_stop_sync && r_state != S_ALARM) w_pend_nxt = '0;
  end

  always_comb begin
    w_zone_nxt = 2'd0;
    if (w_state_nxt == S_ALARM) w_zone_nxt = w_grant ? (w_grant_idx + 2'd1) : alarm_zone;
    case (w_zone_nxt)
      2'd1:    w_digit = 7'b0110000;
      2'd2:    w_digit = 7'b1101101;
      2'd3:    w_digit = 7'b1111001;
      default: w_digit = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_ptr        <= 2'd0;
      pending      <= '0;
      LED          <= 1'b0;
      alarm_zone   <= 2'd0;
      display_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_timer <= '0;
      else if (r_state != S_IDLE) r_timer <= r_timer + 1'b1;
      if (w_grant) r_ptr <= wrap3(3'(w_grant_idx) + 3'd1);
      pending      <= w_pend_nxt;
      LED          <= (w_state_nxt == S_ALARM);
      alarm_zone   <= w_zone_nxt;
      display_data <= (w_state_nxt == S_ALARM) ? {7'b0000000, SEG_A, w_digit} : 21'd0;
    end
  end

`ifdef PIR_BEEP_EN
  localparam int BW = $clog2(BEEP_HALF + 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);
  logic [BW-1:0] r_beep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beep_cnt <= '0;
      buzzer     <= 1'b0;
    end else if (w_state_nxt != S_ALARM) begin
      r_beep_cnt <= '0;
      buzzer     <= 1'b0;
    end else if (r_state != S_ALARM) begin
      r_beep_cnt <= '0;
      buzzer     <= 1'b1;
    end else if (r_beep_cnt == BEEP_LAST) begin
      r_beep_cnt <= '0;
      buzzer     <= ~buzzer;
    end else begin
      r_beep_cnt <= r_beep_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buzzer <= 1'b0;
    else        buzzer <= (w_state_nxt == S_ALARM);
  end
`endif

endmodule

// File: tb/tb_pir_zone_scheduler.sv
// Bench for pir_zone_scheduler: directed scenarios plus random sensor/stop traffic against an event-level model.
module tb_pir_zone_scheduler;
  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int HOLD = 5;
  localparam int BH   = 3;

  logic        clk, rst_n, stop;
  logic [2:0]  sens;
  logic        LED, buzzer;
  logic [20:0] display_data;
  logic [1:0]  alarm_zone;
  logic [2:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  pir_zone_scheduler #(
    .DEBOUNCE_CYCLES(DEB), .ALARM_TIMEOUT(TMO), .HOLDOFF_CYCLES(HOLD), .BEEP_HALF(BH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stop_alarm(stop),
    .pir_sensor_1(sens[0]), .pir_sensor_2(sens[1]), .pir_sensor_3(sens[2]),
    .LED(LED), .buzzer(buzzer), .display_data(display_data),
    .alarm_zone(alarm_zone), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int z);
    case (z)
      1:       return 7'b0110000;
      2:       return 7'b1101101;
      3:       return 7'b1111001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Model: raw-sample histories, the zone in service with its age, and remaining hold-off cycles.
  logic [31:0] h_s [3];
  logic [31:0] h_stop;
  logic [2:0]  m_deb, m_pend, m_rise, m_gbit;
  int          m_zone, m_age, m_hold, m_last, m_pick;
  logic        m_stop_s, m_was_alarm, m_was_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < 3; z++) h_s[z] = '0;
      h_stop = '0; m_deb = '0; m_pend = '0;
      m_zone = 0; m_age = 0; m_hold = 0; m_last = 3;
    end else begin
      // The synchronized level seen at this edge is the raw level sampled two edges ago.
      m_stop_s = h_stop[1];
      m_rise   = '0;
      for (int z = 0; z < 3; z++) begin
        if (!m_deb[z] && h_s[z][DEB:1] == {DEB{1'b1}}) begin
          m_rise[z] = 1'b1;
          m_deb[z]  = 1'b1;
        end else if (m_deb[z] && h_s[z][DEB:1] == {DEB{1'b0}}) begin
          m_deb[z] = 1'b0;
        end
      end
      m_was_alarm = (m_zone != 0);
      m_was_idle  = (m_zone == 0) && (m_hold == 0);
      m_gbit = '0;
      if (m_was_idle && m_pend != 0 && !m_stop_s) begin
        m_pick = 0;
        for (int k = 1; k <= 3; k++) begin
          int cand;
          cand = (m_last + k - 1) % 3 + 1;
          if (m_pick == 0 && m_pend[cand-1]) m_pick = cand;
        end
        m_zone = m_pick; m_age = 1; m_last = m_pick;
        m_gbit[m_pick-1] = 1'b1;
      end else if (m_was_alarm) begin
        if (m_stop_s || m_age == TMO) begin
          m_zone = 0; m_age = 0; m_hold = HOLD;
        end else begin
          m_age++;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end
      m_pend = (m_pend & ~m_gbit) | m_rise;
      if (m_stop_s && !m_was_alarm) m_pend = '0;
      for (int z = 0; z < 3; z++) h_s[z] = {h_s[z][30:0], sens[z]};
      h_stop = {h_stop[30:0], stop};
    end
  end

  function automatic logic exp_buzzer();
`ifdef PIR_BEEP_EN
    return (m_zone != 0) && ((((m_age - 1) / BH) % 2) == 0);
`else
    return (m_zone != 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_eq("led",     LED,        (m_zone != 0));
      check_eq("buzzer",  buzzer,     exp_buzzer());
      check_eq("zone",    alarm_zone, m_zone);
      check_eq("pending", pending,    m_pend);
      check_eq("display", display_data,
               (m_zone == 0) ? 21'd0 : {7'b0000000, 7'b1110111, seg(m_zone)});
    end
  end

  int   served [$];
  logic prev_led;
  always @(negedge clk) begin
    if (!rst_n) prev_led = 1'b0;
    else begin
      if (LED && !prev_led) served.push_back(int'(alarm_zone));
      prev_led = LED;
    end
  end

  task automatic hold(input logic [2:0] s, input logic st, input int n);
    sens = s;
    stop = st;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_led"},  LED,          0);
    check_eq({tag, "_buz"},  buzzer,       0);
    check_eq({tag, "_disp"}, display_data, 0);
    check_eq({tag, "_zone"}, alarm_zone,   0);
    check_eq({tag, "_pend"}, pending,      0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi;
    rst_n = 1'b1; sens = '0; stop = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    @(negedge clk); rst_n = 1'b1; chk_en = 1;

    // Glitch shorter than the debounce window, then a real zone 2 event.
    hold(3'b010, 0, 3);
    hold(3'b000, 0, 10);
    check_eq("glitch_pend", pending, 0);
    hold(3'b010, 0, 5);
    check_eq("deb_early", pending, 0);
    hold(3'b010, 0, 1);
    check_eq("deb_pend", pending, 3'b010);
    hold(3'b010, 0, 1);
    check_eq("z2_zone", alarm_zone, 2);
    check_eq("z2_disp", display_data, {7'b0000000, 7'b1110111, 7'b1101101});
    hold(3'b010, 0, 3);
    hold(3'b000, 0, 40);

    // Timeout path: LED high for exactly the timeout.
    hold(3'b001, 0, 6);
    sens = 3'b000;
    n_hi = 0;
    repeat (45) begin
      @(negedge clk);
      if (LED) n_hi++;
    end
    check_eq("tmo_len", n_hi, TMO);

    // Stop pulse: HOLDOFF two edges after first sampling.
    hold(3'b010, 0, 7);
    check_eq("stop_pre", LED, 1);
    hold(3'b000, 1, 2);
    check_eq("stop_m1", LED, 1);
    hold(3'b000, 1, 1);
    check_eq("stop_m2", LED, 0);
    hold(3'b000, 0, 30);

    // Master silence with all zones pending.
    hold(3'b111, 0, 7);
    check_eq("ms_alarm", LED, 1);
    hold(3'b111, 1, 12);
    check_eq("ms_pend", pending, 0);
    hold(3'b000, 1, 2);
    stop = 1'b0;
    n_hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (LED) n_hi++;
    end
    check_eq("ms_quiet", n_hi, 0);

    // Reset in the middle of an alarm.
    hold(3'b001, 0, 7);
    hold(3'b000, 0, 3);
    check_eq("rst_pre", LED, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    hold(3'b000, 0, 3);
    check_eq("rst_idle", LED, 0);

    // Round-robin from a fresh pointer.
    served.delete();
    hold(3'b111, 0, 8);
    hold(3'b000, 0, 100);
    check_eq("rr_count", served.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq("rr_order", (i < served.size()) ? served[i] : 0, i + 1);
    served.delete();
    hold(3'b101, 0, 8);
    hold(3'b000, 0, 70);
    check_eq("rr_wrap_n", served.size(), 2);
    check_eq("rr_wrap", (served.size() > 0) ? served[0] : 0, 1);

    // Zone 3 re-triggers during its own alarm.
    served.delete();
    hold(3'b100, 0, 7);
    hold(3'b000, 0, 6);
    hold(3'b100, 0, 6);
    check_eq("retrig_zone", alarm_zone, 3);
    check_eq("retrig_pend", pending, 3'b100);
    hold(3'b100, 0, 40);
    hold(3'b000, 0, 40);
    check_eq("retrig_n", served.size(), 2);
    check_eq("retrig_2nd", (served.size() > 1) ? served[1] : 0, 3);

    // Random traffic.
    for (int seg_i = 0; seg_i < 250; seg_i++) begin
      logic [2:0] s;
      logic       st;
      s  = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 7) == 0);
      hold(s, st, int'($urandom_range(1, 12)));
    end
    hold(3'b000, 0, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
